serial_clock_edge_detector: RTL and testbench

Upstream stage of the serial read/write buffers. It synchronises an external, asynchronous serial clock and chip-select into the sys_clk domain and filters out glitches. It then emits single-cycle read_sig (sample) and write_sig (shift) strobes according to the SPI mode, and tracks frame boundaries and the bit count within each frame.

---
 rtl/serial_clock_edge_detector.sv | 185 ++++++++++++++++++
 tb/tb_serial_clock_edge_detector.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_clock_edge_detector.sv
// Synchronises and deglitches an external serial clock and chip select, then issues
// single-cycle sample/shift strobes per SPI mode and tracks frame boundaries and bit count.
module serial_clock_edge_detector #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 1,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 ser_clk_in,
  input  logic                 ser_cs_n_in,
  output logic                 read_sig,
  output logic                 write_sig,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 cs_active,
  output logic [CNT_WIDTH-1:0] bit_cnt
);

  localparam int unsigned FCW        = $clog2(FILTER_LEN + 1);
  localparam int unsigned PRIME_LEN  = SYNC_STAGES + FILTER_LEN;
  localparam int unsigned PCW        = $clog2(PRIME_LEN + 1);
  localparam logic             IDLE_CLK   = 1'(CPOL);
  localparam logic [FCW-1:0]   FLT_LAST   = FCW'(FILTER_LEN - 1);
  localparam logic [PCW-1:0]   PRIME_DONE = PCW'(PRIME_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_WAIT_RELEASE = 2'd0,
    ST_IDLE         = 2'd1,
    ST_ACTIVE       = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [FCW-1:0]         clk_fcnt_q, clk_fcnt_d;
  logic [FCW-1:0]         cs_fcnt_q, cs_fcnt_d;
  logic                   clk_filt_q, clk_filt_d;
  logic                   cs_filt_q, cs_filt_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [PCW-1:0]         prime_cnt_q, prime_cnt_d;

  logic                   read_sig_q, read_sig_d;
  logic                   write_sig_q, write_sig_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_end_q, frame_end_d;
  logic                   cs_active_q, cs_active_d;
  logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;

  logic clk_synced_c, cs_synced_c;
  logic clk_lead_c, clk_trail_c, sample_edge_c, shift_edge_c;
  logic cs_fall_c, cs_rise_c;

  // Synchroniser chains and glitch filters
  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ser_clk_in};
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], ser_cs_n_in};
    clk_synced_c = clk_sync_q[SYNC_STAGES-1];
    cs_synced_c  = cs_sync_q[SYNC_STAGES-1];

    clk_filt_d = clk_filt_q;
    clk_fcnt_d = '0;
    if (clk_synced_c != clk_filt_q) begin
      if (clk_fcnt_q == FLT_LAST) clk_filt_d = clk_synced_c;
      else                        clk_fcnt_d = clk_fcnt_q + FCW'(1);
    end

    cs_filt_d = cs_filt_q;
    cs_fcnt_d = '0;
    if (cs_synced_c != cs_filt_q) begin
      if (cs_fcnt_q == FLT_LAST) cs_filt_d = cs_synced_c;
      else                       cs_fcnt_d = cs_fcnt_q + FCW'(1);
    end

    clk_prev_d = clk_filt_q;
    cs_prev_d  = cs_filt_q;

    // Filtered cs only reflects the real pin once the pipeline has flushed after reset
    prime_cnt_d = prime_cnt_q;
    if (prime_cnt_q != PRIME_DONE) prime_cnt_d = prime_cnt_q + PCW'(1);
  end

  always_comb begin
    clk_lead_c    = (clk_prev_q == IDLE_CLK) && (clk_filt_q != IDLE_CLK);
    clk_trail_c   = (clk_prev_q != IDLE_CLK) && (clk_filt_q == IDLE_CLK);
    sample_edge_c = (CPHA == 0) ? clk_lead_c : clk_trail_c;
    shift_edge_c  = (CPHA == 0) ? clk_trail_c : clk_lead_c;
    cs_fall_c     = cs_prev_q && !cs_filt_q;
    cs_rise_c     = !cs_prev_q && cs_filt_q;
  end

  // Frame FSM next-state and strobe generation
  always_comb begin
    state_d       = state_q;
    read_sig_d    = 1'b0;
    write_sig_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    bit_cnt_d     = bit_cnt_q;

    case (state_q)
      ST_WAIT_RELEASE: begin
        if (cs_filt_q && (prime_cnt_q == PRIME_DONE)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (cs_fall_c && enable) begin
          state_d       = ST_ACTIVE;
          frame_start_d = 1'b1;
          bit_cnt_d     = '0;
          write_sig_d   = (CPHA == 0);
        end
      end
      ST_ACTIVE: begin
        if (!enable) begin
          state_d     = ST_WAIT_RELEASE;
          frame_end_d = 1'b1;
        end else if (cs_rise_c) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
        end else begin
          if (sample_edge_c) begin
            read_sig_d = 1'b1;
            if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
          end
          if (shift_edge_c) write_sig_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT_RELEASE;
    endcase

    cs_active_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_WAIT_RELEASE;
      clk_sync_q    <= {SYNC_STAGES{IDLE_CLK}};
      cs_sync_q     <= {SYNC_STAGES{1'b1}};
      clk_fcnt_q    <= '0;
      cs_fcnt_q     <= '0;
      clk_filt_q    <= IDLE_CLK;
      cs_filt_q     <= 1'b1;
      clk_prev_q    <= IDLE_CLK;
      cs_prev_q     <= 1'b1;
      prime_cnt_q   <= '0;
      read_sig_q    <= 1'b0;
      write_sig_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      cs_active_q   <= 1'b0;
      bit_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      cs_sync_q     <= cs_sync_d;
      clk_fcnt_q    <= clk_fcnt_d;
      cs_fcnt_q     <= cs_fcnt_d;
      clk_filt_q    <= clk_filt_d;
      cs_filt_q     <= cs_filt_d;
      clk_prev_q    <= clk_prev_d;
      cs_prev_q     <= cs_prev_d;
      prime_cnt_q   <= prime_cnt_d;
      read_sig_q    <= read_sig_d;
      write_sig_q   <= write_sig_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      cs_active_q   <= cs_active_d;
      bit_cnt_q     <= bit_cnt_d;
    end
  end

  assign read_sig    = read_sig_q;
  assign write_sig   = write_sig_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign cs_active   = cs_active_q;
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_serial_clock_edge_detector.sv
// Bench for serial_clock_edge_detector: three configurations (mode 0, CPOL1/CPHA1, long filter)
// checked cycle by cycle against a sample-history reference model, plus directed scenarios.
module tb_serial_clock_edge_detector;

  localparam int CW  = 8;
  localparam int ND  = 3;
  localparam int P_S = 2;
  localparam int M_WAIT = 0, M_IDLE = 1, M_ACTIVE = 2;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          sclk  [ND];
  logic          scs_n [ND];
  logic          rd [ND], wr [ND], fs [ND], fe [ND], act [ND];
  logic [CW-1:0] cnt [ND];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        chk_on = 1'b0;
  int          n_rd [ND], n_wr [ND], n_fs [ND], n_fe [ND];

  serial_clock_edge_detector #(.SYNC_STAGES(2), .FILTER_LEN(1), .CPOL(0), .CPHA(0), .CNT_WIDTH(CW))
    u_dut_m0 (.sys_clk(sys_clk), .rst(rst), .enable(enable), .ser_clk_in(sclk[0]),
              .ser_cs_n_in(scs_n[0]), .read_sig(rd[0]), .write_sig(wr[0]), .frame_start(fs[0]),
              .frame_end(fe[0]), .cs_active(act[0]), .bit_cnt(cnt[0]));

  serial_clock_edge_detector #(.SYNC_STAGES(2), .FILTER_LEN(1), .CPOL(1), .CPHA(1), .CNT_WIDTH(CW))
    u_dut_m3 (.sys_clk(sys_clk), .rst(rst), .enable(enable), .ser_clk_in(sclk[1]),
              .ser_cs_n_in(scs_n[1]), .read_sig(rd[1]), .write_sig(wr[1]), .frame_start(fs[1]),
              .frame_end(fe[1]), .cs_active(act[1]), .bit_cnt(cnt[1]));

  serial_clock_edge_detector #(.SYNC_STAGES(2), .FILTER_LEN(3), .CPOL(0), .CPHA(0), .CNT_WIDTH(CW))
    u_dut_flt (.sys_clk(sys_clk), .rst(rst), .enable(enable), .ser_clk_in(sclk[2]),
               .ser_cs_n_in(scs_n[2]), .read_sig(rd[2]), .write_sig(wr[2]), .frame_start(fs[2]),
               .frame_end(fe[2]), .cs_active(act[2]), .bit_cnt(cnt[2]));

  always #5 sys_clk = ~sys_clk;

  function automatic logic p_cpol(input int d);
    return (d == 1);
  endfunction

  function automatic logic p_cpha(input int d);
    return (d == 1);
  endfunction

  function automatic int p_f(input int d);
    return (d == 2) ? 3 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last f synchronised samples all disagree with it.
  logic [7:0]    m_ch [ND], m_sh [ND];
  logic [1:0]    m_cf [ND], m_sf [ND];
  int            m_mode [ND], m_age [ND];
  logic          e_rd [ND], e_wr [ND], e_fs [ND], e_fe [ND], e_act [ND];
  logic [CW-1:0] e_cnt [ND];

  function automatic logic settled_away(input logic [7:0] hist, input int f, input logic cur);
    for (int i = P_S - 1; i <= P_S + f - 2; i++)
      if (hist[3'(i)] == cur) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input int d);
    logic cpol, cpha, c_prev, c_cur, s_prev, s_cur, lead, trail, samp, shft, c_new, s_new;
    cpol = p_cpol(d);
    cpha = p_cpha(d);
    if (rst) begin
      m_ch[d] = {8{cpol}};  m_sh[d] = 8'hFF;
      m_cf[d] = {2{cpol}};  m_sf[d] = 2'b11;
      m_mode[d] = M_WAIT;   m_age[d] = 0;
      e_rd[d] = 1'b0; e_wr[d] = 1'b0; e_fs[d] = 1'b0; e_fe[d] = 1'b0; e_act[d] = 1'b0;
      e_cnt[d] = '0;
    end else begin
      c_prev = m_cf[d][1]; c_cur = m_cf[d][0];
      s_prev = m_sf[d][1]; s_cur = m_sf[d][0];
      lead  = (c_prev == cpol) && (c_cur != cpol);
      trail = (c_prev != cpol) && (c_cur == cpol);
      samp  = cpha ? trail : lead;
      shft  = cpha ? lead : trail;
      e_rd[d] = 1'b0; e_wr[d] = 1'b0; e_fs[d] = 1'b0; e_fe[d] = 1'b0;
      if (m_mode[d] == M_WAIT) begin
        if (s_cur && m_age[d] >= P_S + p_f(d)) m_mode[d] = M_IDLE;
      end else if (m_mode[d] == M_IDLE) begin
        if (s_prev && !s_cur && enable) begin
          m_mode[d] = M_ACTIVE; e_fs[d] = 1'b1; e_cnt[d] = '0; e_wr[d] = !cpha;
        end
      end else begin
        if (!enable) begin
          m_mode[d] = M_WAIT; e_fe[d] = 1'b1;
        end else if (!s_prev && s_cur) begin
          m_mode[d] = M_IDLE; e_fe[d] = 1'b1;
        end else begin
          if (samp) begin
            e_rd[d] = 1'b1;
            if (e_cnt[d] != 8'hFF) e_cnt[d] = e_cnt[d] + 8'd1;
          end
          if (shft) e_wr[d] = 1'b1;
        end
      end
      e_act[d] = (m_mode[d] == M_ACTIVE);
      if (m_age[d] < 100) m_age[d]++;
      c_new = settled_away(m_ch[d], p_f(d), c_cur) ? ~c_cur : c_cur;
      s_new = settled_away(m_sh[d], p_f(d), s_cur) ? ~s_cur : s_cur;
      m_cf[d] = {c_cur, c_new};
      m_sf[d] = {s_cur, s_new};
      m_ch[d] = {m_ch[d][6:0], sclk[d]};
      m_sh[d] = {m_sh[d][6:0], scs_n[d]};
    end
  endtask

  always @(posedge sys_clk) begin
    for (int d = 0; d < ND; d++) model_step(d);
  end

  // Cycle-level comparison and strobe tallies
  always @(negedge sys_clk) begin
    if (chk_on) begin
      for (int d = 0; d < ND; d++) begin
        check_eq($sformatf("dut%0d_cycle", d),
                 32'({rd[d], wr[d], fs[d], fe[d], act[d], cnt[d]}),
                 32'({e_rd[d], e_wr[d], e_fs[d], e_fe[d], e_act[d], e_cnt[d]}));
        if (rd[d]) n_rd[d]++;
        if (wr[d]) n_wr[d]++;
        if (fs[d]) n_fs[d]++;
        if (fe[d]) n_fe[d]++;
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic set_clk(input logic c);
    sclk[0] = c; sclk[1] = ~c; sclk[2] = c;
  endtask

  task automatic set_cs(input logic v);
    for (int d = 0; d < ND; d++) scs_n[d] = v;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < ND; d++) begin
      n_rd[d] = 0; n_wr[d] = 0; n_fs[d] = 0; n_fe[d] = 0;
    end
  endtask

  task automatic ser_cycles(input int n, input int unsigned half);
    for (int i = 0; i < n; i++) begin
      set_clk(1'b1); tick(half);
      set_clk(1'b0); tick(half);
    end
  endtask

  initial begin
    int unsigned half, nclk, gd;
    rst = 1'b1; enable = 1'b1;
    set_clk(1'b0); set_cs(1'b1);
    clear_counts();
    tick(3);
    for (int d = 0; d < ND; d++)
      check_eq($sformatf("reset_dut%0d", d), 32'({rd[d], wr[d], fs[d], fe[d], act[d], cnt[d]}), 32'd0);
    rst = 1'b0; chk_on = 1'b1;
    tick(10);

    // Mode 0 frame of 8 clocks; last falling edge coincides with cs release
    clear_counts();
    set_cs(1'b0);
    tick(3);
    check_eq("p1_fs_early", 32'(fs[0]), 32'd0);
    tick(1);
    check_eq("p1_fs_wr_act", 32'({fs[0], wr[0], act[0]}), 32'b111);
    check_eq("p1_m3_fs_nowr", 32'({fs[1], wr[1]}), 32'b10);
    tick(6);
    for (int i = 1; i <= 8; i++) begin
      set_clk(1'b1); tick(10);
      set_clk(1'b0);
      if (i == 8) set_cs(1'b1);
      tick(10);
    end
    tick(10);
    check_eq("p1_reads", 32'(n_rd[0]), 32'd8);
    check_eq("p1_writes", 32'(n_wr[0]), 32'd8);
    check_eq("p1_frame_end", 32'(n_fe[0]), 32'd1);
    check_eq("p1_bit_cnt", 32'(cnt[0]), 32'd8);
    check_eq("p1_m3_reads", 32'(n_rd[1]), 32'd7);

    // CPOL=1/CPHA=1 frame of 4 clocks
    clear_counts();
    set_cs(1'b0); tick(10);
    ser_cycles(4, 10); tick(10);
    set_cs(1'b1); tick(10);
    check_eq("p2_m3_writes", 32'(n_wr[1]), 32'd4);
    check_eq("p2_m3_reads", 32'(n_rd[1]), 32'd4);
    check_eq("p2_m3_bit_cnt", 32'(cnt[1]), 32'd4);
    check_eq("p2_m0_writes", 32'(n_wr[0]), 32'd5);

    // Glitch rejection with FILTER_LEN=3
    clear_counts();
    set_cs(1'b0); tick(10);
    sclk[2] = 1'b1; tick(2); sclk[2] = 1'b0; tick(10);
    check_eq("p3_glitch_reads", 32'(n_rd[2]), 32'd0);
    check_eq("p3_glitch_cnt", 32'(cnt[2]), 32'd0);
    sclk[2] = 1'b1; tick(3); sclk[2] = 1'b0; tick(10);
    check_eq("p3_pulse_reads", 32'(n_rd[2]), 32'd1);
    check_eq("p3_pulse_cnt", 32'(cnt[2]), 32'd1);
    set_cs(1'b1); tick(10);

    // Reset mid-frame with cs held low
    set_cs(1'b0); tick(10);
    ser_cycles(2, 10);
    set_clk(1'b1); tick(4);
    rst = 1'b1; #1;
    for (int d = 0; d < ND; d++)
      check_eq($sformatf("p4_rst_dut%0d", d), 32'({rd[d], wr[d], fs[d], fe[d], act[d], cnt[d]}), 32'd0);
    set_clk(1'b0); tick(3);
    rst = 1'b0; clear_counts();
    ser_cycles(3, 10);
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("p4_no_fs_dut%0d", d), 32'(n_fs[d]), 32'd0);
      check_eq($sformatf("p4_no_rd_dut%0d", d), 32'(n_rd[d]), 32'd0);
    end
    set_cs(1'b1); tick(10);
    set_cs(1'b0); tick(10);
    check_eq("p4_fs_after_release", 32'(n_fs[0]), 32'd1);
    set_cs(1'b1); tick(10);

    // Enable dropped mid-frame, raised while cs still low
    clear_counts();
    set_cs(1'b0); tick(10);
    ser_cycles(2, 10);
    enable = 1'b0; tick(1);
    check_eq("p5_fe_act", 32'({fe[0], act[0]}), 32'b10);
    ser_cycles(2, 10);
    enable = 1'b1;
    ser_cycles(2, 10);
    check_eq("p5_reads", 32'(n_rd[0]), 32'd2);
    check_eq("p5_fs", 32'(n_fs[0]), 32'd1);
    check_eq("p5_fe", 32'(n_fe[0]), 32'd1);
    set_cs(1'b1); tick(10);
    set_cs(1'b0); tick(10);
    check_eq("p5_fs_next", 32'(n_fs[0]), 32'd2);
    set_cs(1'b1); tick(10);

    // cs release together with a sample edge
    clear_counts();
    set_cs(1'b0); tick(10);
    ser_cycles(1, 10);
    set_clk(1'b1); set_cs(1'b1); tick(10);
    set_clk(1'b0); tick(10);
    check_eq("p6_reads", 32'(n_rd[0]), 32'd1);
    check_eq("p6_bit_cnt", 32'(cnt[0]), 32'd1);
    check_eq("p6_fe", 32'(n_fe[0]), 32'd1);

    // Bit counter saturation
    clear_counts();
    set_cs(1'b0); tick(10);
    ser_cycles(300, 5); tick(5);
    set_cs(1'b1); tick(10);
    check_eq("p6_sat_reads", 32'(n_rd[0]), 32'd300);
    check_eq("p6_sat_cnt", 32'(cnt[0]), 32'd255);
    check_eq("p6_sat_cnt_flt", 32'(cnt[2]), 32'd255);

    // Randomised frames: glitches, enable drops, coincident edges, resets
    for (int f = 0; f < 40; f++) begin
      half = $urandom_range(1, 12);
      nclk = $urandom_range(0, 10);
      set_cs(1'b0); tick($urandom_range(1, 12));
      for (int i = 0; i < int'(nclk); i++) begin
        set_clk(1'b1); tick(half);
        if ($urandom_range(0, 5) == 0) begin
          gd = $urandom_range(0, 2);
          sclk[gd] = ~sclk[gd]; tick($urandom_range(1, 3));
          sclk[gd] = ~sclk[gd];
        end
        set_clk(1'b0); tick(half);
        if ($urandom_range(0, 15) == 0) enable = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) set_clk(1'b1);
      set_cs(1'b1); tick($urandom_range(1, 12));
      set_clk(1'b0); enable = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1; tick(2); rst = 1'b0;
      end
      tick($urandom_range(4, 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
